// File: rtl/int_to_fp_converter.sv
// Multi-cycle signed/unsigned integer to IEEE-754 single converter, round-to-nearest-even.
// Define FAST_NORM_EN for single-cycle normalisation via a leading-zero count.
module int_to_fp_converter #(
    parameter int INT_WIDTH = 32,
    parameter bit SIGNED_IN = 1'b1
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [INT_WIDTH-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_t;

    state_t      r_state;
    logic        r_sign;
    logic [31:0] r_mag;
    logic [7:0]  r_exp;
    logic        r_out_valid;
    logic [31:0] r_out_data;

    logic [31:0] w_ext;
    logic        w_sign_in;
    logic [31:0] w_mag_in;

    // Negating in 32 bits keeps the most negative input exact (2^31 fits unsigned).
    always_comb begin
        w_ext     = '0;
        w_sign_in = 1'b0;
        if (SIGNED_IN) begin
            w_ext     = 32'($signed(in_data));
            w_sign_in = in_data[INT_WIDTH-1];
        end else begin
            w_ext = 32'(in_data);
        end
        w_mag_in = w_sign_in ? (32'd0 - w_ext) : w_ext;
    end

    logic [22:0] w_mant;
    logic        w_guard;
    logic        w_sticky;
    logic        w_round_up;
    logic [23:0] w_mant_sum;
    logic        w_carry;
    logic [22:0] w_mant_final;
    logic [7:0]  w_exp_final;

    always_comb begin
        w_mant       = r_mag[30:8];
        w_guard      = r_mag[7];
        w_sticky     = |r_mag[6:0];
        w_round_up   = w_guard && (w_sticky || w_mant[0]);
        w_mant_sum   = {1'b0, w_mant} + 24'(w_round_up);
        w_carry      = w_mant_sum[23];
        w_mant_final = w_carry ? '0 : w_mant_sum[22:0];
        w_exp_final  = r_exp + 8'(w_carry);
    end

`ifdef FAST_NORM_EN
    logic [4:0] w_lz;

    // Ascending scan: the highest set bit is the last to write w_lz.
    always_comb begin
        w_lz = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (r_mag[i]) begin
                w_lz = 5'(31 - i);
            end
        end
    end
`endif

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state     <= S_IDLE;
            r_sign      <= 1'b0;
            r_mag       <= '0;
            r_exp       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_sign <= w_sign_in;
                        r_mag  <= w_mag_in;
                        r_exp  <= 8'd158;
                        if (w_mag_in == '0) begin
                            r_out_data  <= '0;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_state <= S_NORM;
                        end
                    end
                end
                S_NORM: begin
`ifdef FAST_NORM_EN
                    r_mag   <= r_mag << w_lz;
                    r_exp   <= r_exp - {3'b000, w_lz};
                    r_state <= S_ROUND;
`else
                    if (r_mag[31]) begin
                        r_state <= S_ROUND;
                    end else begin
                        r_mag <= {r_mag[30:0], 1'b0};
                        r_exp <= r_exp - 8'd1;
                    end
`endif
                end
                S_ROUND: begin
                    r_out_data  <= {r_sign, w_exp_final, w_mant_final};
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_int_to_fp_converter.sv
// Directed-vector bench for int_to_fp_converter: results, latency, backpressure, mid-run reset.
module tb_int_to_fp_converter;

    logic        CLK;
    logic        RESET;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    int n_cmp;
    int n_fail;

    int_to_fp_converter #(
        .INT_WIDTH(32),
        .SIGNED_IN(1'b1)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic [31:0] din;
        logic [31:0] dout;
        int          lat;       // edges after accept until out_valid, bit-serial build
        int          lat_fast;  // same, FAST_NORM_EN build
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called one time unit after a rising edge; returns at the same phase.
    task automatic run_vec(input vec_t v);
        int edges;
        int exp_lat;
        logic ready_leak;
`ifdef FAST_NORM_EN
        exp_lat = v.lat_fast;
`else
        exp_lat = v.lat;
`endif
        check({v.name, " in_ready idle"}, 32'(in_ready), 32'd1);
        in_data  = v.din;
        in_valid = 1'b1;
        @(posedge CLK);
        #1;
        in_valid   = 1'b0;
        edges      = 0;
        ready_leak = 1'b0;
        while (!out_valid && edges < 100) begin
            if (in_ready) ready_leak = 1'b1;
            @(posedge CLK);
            #1;
            edges++;
        end
        check({v.name, " out_valid"}, 32'(out_valid), 32'd1);
        check({v.name, " latency"}, 32'(edges), 32'(exp_lat));
        check({v.name, " out_data"}, out_data, v.dout);
        check({v.name, " in_ready busy"}, 32'(in_ready | ready_leak), 32'd0);
        out_ready = 1'b1;
        @(posedge CLK);
        #1;
        out_ready = 1'b0;
        check({v.name, " out_valid drop"}, 32'(out_valid), 32'd0);
        check({v.name, " in_ready back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic seen_valid;
        n_cmp     = 0;
        n_fail    = 0;
        RESET     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        vecs[0]  = '{"five",      32'd5,          32'h40A00000, 31, 2};
        vecs[1]  = '{"minus_one", 32'hFFFFFFFF,   32'hBF800000, 33, 2};
        vecs[2]  = '{"zero",      32'd0,          32'h00000000, 0,  0};
        vecs[3]  = '{"tie_down",  32'd16777217,   32'h4B800000, 9,  2};
        vecs[4]  = '{"tie_up",    32'd16777219,   32'h4B800002, 9,  2};
        vecs[5]  = '{"carry",     32'h7FFFFFFF,   32'h4F000000, 3,  2};
        vecs[6]  = '{"most_neg",  32'h80000000,   32'hCF000000, 2,  2};
        vecs[7]  = '{"one",       32'd1,          32'h3F800000, 33, 2};
        vecs[8]  = '{"exact24",   32'h00FFFFFF,   32'h4B7FFFFF, 10, 2};
        vecs[9]  = '{"exact25",   32'd16777218,   32'h4B800001, 9,  2};
        vecs[10] = '{"pow30",     32'h40000000,   32'h4E800000, 3,  2};
        vecs[11] = '{"minus5",    32'hFFFFFFFB,   32'hC0A00000, 31, 2};

        #12;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_data", out_data, 32'h0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK);
        #1;

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i]);
        end

        // Backpressure: result held for 10 cycles while the source pokes in_valid.
        in_data  = 32'd5;
        in_valid = 1'b1;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 100 && !out_valid; i++) begin
            @(posedge CLK);
            #1;
        end
        for (int i = 0; i < 10; i++) begin
            in_data  = 32'd7;
            in_valid = (i % 2 == 0);
            @(posedge CLK);
            #1;
            check("bp out_valid", 32'(out_valid), 32'd1);
            check("bp out_data", out_data, 32'h40A00000);
            check("bp in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge CLK);
        #1;
        out_ready = 1'b0;
        check("bp release out_valid", 32'(out_valid), 32'd0);
        check("bp release in_ready", 32'(in_ready), 32'd1);
        run_vec(vecs[10]);

        // Reset asserted mid-normalisation must abort with no output.
        in_data  = 32'd1;
        in_valid = 1'b1;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge CLK);
        #2;
        RESET = 1'b0;
        #1;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst out_data", out_data, 32'h0);
        @(negedge CLK);
        RESET = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK);
            #1;
            if (out_valid) seen_valid = 1'b1;
        end
        check("rst no stale result", 32'(seen_valid), 32'd0);
        run_vec(vecs[11]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
